// File: rtl/cci_mpf_rd_req_sched.sv
// Round-robin read-request scheduler for the MPF c0 channel with global and per-requester credit limits.
// Optional stall statistics: define CCI_MPF_RD_SCHED_STATS_EN.
module cci_mpf_rd_req_sched #(
   parameter int N_REQ           = 4,
   parameter int MAX_ACTIVE_REQS = 128,
   parameter int MAX_PER_REQ     = 64,
   parameter int ADDR_WIDTH      = 42,
   parameter int MDATA_WIDTH     = 16,
   localparam int IDX_W = $clog2(N_REQ),
   localparam int CNT_W = $clog2(MAX_ACTIVE_REQS + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [N_REQ*MDATA_WIDTH-1:0] req_mdata,
   output logic [N_REQ-1:0]             req_ready,
   input  logic                         fiu_almost_full,
   output logic                         tx_valid,
   output logic [ADDR_WIDTH-1:0]        tx_addr,
   output logic [MDATA_WIDTH-1:0]       tx_mdata,
   output logic [IDX_W-1:0]             tx_req_idx,
   input  logic                         rsp_valid,
   input  logic                         rsp_eop,
   input  logic [IDX_W-1:0]             rsp_req_idx,
   output logic                         err_underflow,
   output logic [31:0]                  stat_stall_cycles
);

   localparam logic [CNT_W-1:0] MAX_ACTIVE_C = CNT_W'(MAX_ACTIVE_REQS);
   localparam logic [CNT_W-1:0] MAX_PER_C    = CNT_W'(MAX_PER_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_REQ - 1);

   logic [CNT_W-1:0] cnt [N_REQ];
   logic [CNT_W-1:0] total_cnt;
   logic [IDX_W-1:0] rr_ptr;
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] rsp_dec;
   logic             grant_vld;
   logic [IDX_W-1:0] grant_idx;
   logic             rsp_eop_v;
   logic             underflow;
   int               k;
   logic [IDX_W-1:0] kidx;

   // Handshake: a request transfers on req_valid[i] && req_ready[i]. req_ready is at most one-hot
   // and only rises for a requester already presenting valid; requesters must not wait on ready.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = !reset && req_valid[i] && !fiu_almost_full &&
                   (total_cnt < MAX_ACTIVE_C) && (cnt[i] < MAX_PER_C);
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      k         = 0;
      kidx      = '0;
      for (int off = 0; off < N_REQ; off++) begin
         k = int'(rr_ptr) + off;
         if (k >= N_REQ) k = k - N_REQ;
         kidx = IDX_W'(k);
         if (!grant_vld && elig[kidx]) begin
            grant_vld = 1'b1;
            grant_idx = kidx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_vld) req_ready[grant_idx] = 1'b1;
   end

   // An index with no matching live counter (zero count or out of range) is an underflow.
   assign rsp_eop_v = rsp_valid && rsp_eop;
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         rsp_dec[i] = rsp_eop_v && (rsp_req_idx == IDX_W'(i)) && (cnt[i] != '0);
      end
   end
   assign underflow = rsp_eop_v && !(|rsp_dec);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
         total_cnt     <= '0;
         rr_ptr        <= '0;
         err_underflow <= 1'b0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i] && !rsp_dec[i])      cnt[i] <= cnt[i] + 1'b1;
            else if (rsp_dec[i] && !req_ready[i]) cnt[i] <= cnt[i] - 1'b1;
         end
         if (grant_vld && !(|rsp_dec))      total_cnt <= total_cnt + 1'b1;
         else if (!grant_vld && (|rsp_dec)) total_cnt <= total_cnt - 1'b1;
         if (grant_vld) rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
         if (underflow) err_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_valid   <= 1'b0;
         tx_addr    <= '0;
         tx_mdata   <= '0;
         tx_req_idx <= '0;
      end else begin
         tx_valid <= grant_vld;
         if (grant_vld) begin
            tx_addr    <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            tx_mdata   <= req_mdata[int'(grant_idx)*MDATA_WIDTH +: MDATA_WIDTH];
            tx_req_idx <= grant_idx;
         end
      end
   end

`ifdef CCI_MPF_RD_SCHED_STATS_EN
   logic [31:0] stall_cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if ((|req_valid) && !grant_vld && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
   assign stat_stall_cycles = stall_cnt;
`else
   assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cci_mpf_rd_req_sched.sv
// Directed bench for cci_mpf_rd_req_sched: arbitration order, credit limits, backpressure, underflow, reset.
module tb_cci_mpf_rd_req_sched;
   localparam int N  = 4;
   localparam int AW = 42;
   localparam int MW = 16;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*MW-1:0] req_mdata;
   logic [N-1:0]    req_ready;
   logic            fiu_almost_full;
   logic            tx_valid;
   logic [AW-1:0]   tx_addr;
   logic [MW-1:0]   tx_mdata;
   logic [IW-1:0]   tx_req_idx;
   logic            rsp_valid;
   logic            rsp_eop;
   logic [IW-1:0]   rsp_req_idx;
   logic            err_underflow;
   logic [31:0]     stat_stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;
   logic [IW-1:0] exp_q[$];

   cci_mpf_rd_req_sched #(
      .N_REQ(N), .MAX_ACTIVE_REQS(8), .MAX_PER_REQ(4), .ADDR_WIDTH(AW), .MDATA_WIDTH(MW)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_mdata(req_mdata), .req_ready(req_ready), .fiu_almost_full(fiu_almost_full),
      .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_mdata(tx_mdata), .tx_req_idx(tx_req_idx),
      .rsp_valid(rsp_valid), .rsp_eop(rsp_eop), .rsp_req_idx(rsp_req_idx),
      .err_underflow(err_underflow), .stat_stall_cycles(stat_stall_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [AW-1:0] addr_of(input int i);
      return AW'(64'h2_0000_1000 + 64'(i) * 64'h111);
   endfunction

   function automatic logic [MW-1:0] mdata_of(input int i);
      return MW'(32'hC000 + i);
   endfunction

   // Advance to just after the next rising edge; inputs change here, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid       = '0;
      fiu_almost_full = 1'b0;
      rsp_valid       = 1'b0;
      rsp_eop         = 1'b0;
      rsp_req_idx     = '0;
      reset           = 1'b1;
      step();
      step();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_tx_pop(input string name);
      logic [IW-1:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (tx_valid !== 1'b1 || tx_req_idx !== e || tx_addr !== addr_of(int'(e)) ||
          tx_mdata !== mdata_of(int'(e))) begin
         n_fail++;
         $display("FAIL %s: got v=%b idx=%0d addr=%h md=%h expected v=1 idx=%0d addr=%h md=%h",
                  name, tx_valid, tx_req_idx, tx_addr, tx_mdata, e, addr_of(int'(e)), mdata_of(int'(e)));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '0;
      #3;
      n_tests++;
      if (tx_valid !== 1'b0 || tx_addr !== '0 || tx_mdata !== '0 || tx_req_idx !== '0 ||
          req_ready !== '0 || err_underflow !== 1'b0 || stat_stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b a=%h m=%h i=%0d r=%b e=%b s=%0d expected all 0",
                  tx_valid, tx_addr, tx_mdata, tx_req_idx, req_ready, err_underflow, stat_stall_cycles);
      end
      do_reset();
      step();
      n_tests++;
      if (tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_tx: got %b expected 0", tx_valid);
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] e;
      do_reset();
      req_valid = '1;
      for (int c = 0; c < 8; c++) begin
         #1;
         e = N'(1) << (c % 4);
         n_tests++;
         if (req_ready !== e) begin
            n_fail++;
            $display("FAIL fair_ready[%0d]: got %b expected %b", c, req_ready, e);
         end
         exp_q.push_back(IW'(c % 4));
         step();
         check_tx_pop("fair_tx");
      end
      #1;
      n_tests++;
      if (req_ready !== '0) begin
         n_fail++;
         $display("FAIL fair_global_stall: got %b expected 0000", req_ready);
      end
      step();
      n_tests++;
      if (tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fair_tx_drop: got %b expected 0", tx_valid);
      end
      req_valid = '0;
   endtask

   task automatic test_global_limit();
      logic [N-1:0] e;
      do_reset();
      req_valid = 4'b0011;
      for (int c = 0; c < 8; c++) begin
         #1;
         e = (c % 2 == 1) ? 4'b0010 : 4'b0001;
         n_tests++;
         if (req_ready !== e) begin
            n_fail++;
            $display("FAIL glob_ready[%0d]: got %b expected %b", c, req_ready, e);
         end
         exp_q.push_back(IW'(c % 2));
         step();
         check_tx_pop("glob_tx");
      end
      rsp_valid = 1'b1; rsp_eop = 1'b1; rsp_req_idx = 2'd1;
      #1;
      n_tests++;
      if (req_ready !== '0) begin
         n_fail++;
         $display("FAIL glob_same_cycle: got %b expected 0000", req_ready);
      end
      step();
      rsp_valid = 1'b0; rsp_eop = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL glob_credit_grant: got %b expected 0010", req_ready);
      end
      exp_q.push_back(2'd1);
      step();
      check_tx_pop("glob_credit_tx");
      #1;
      n_tests++;
      if (req_ready !== '0) begin
         n_fail++;
         $display("FAIL glob_restall: got %b expected 0000", req_ready);
      end
      req_valid = '0;
   endtask

   task automatic test_per_req_limit();
      logic [N-1:0] e;
      logic [31:0]  es;
      do_reset();
      req_valid = 4'b0100;
      for (int c = 0; c < 9; c++) begin
         #1;
         e = (c < 4) ? 4'b0100 : 4'b0000;
         n_tests++;
         if (req_ready !== e) begin
            n_fail++;
            $display("FAIL per_ready[%0d]: got %b expected %b", c, req_ready, e);
         end
         step();
      end
      req_valid = '0;
`ifdef CCI_MPF_RD_SCHED_STATS_EN
      es = 32'd5;
`else
      es = 32'd0;
`endif
      n_tests++;
      if (stat_stall_cycles !== es) begin
         n_fail++;
         $display("FAIL per_stall_cnt: got %0d expected %0d", stat_stall_cycles, es);
      end
      step();
      n_tests++;
      if (stat_stall_cycles !== es) begin
         n_fail++;
         $display("FAIL per_stall_idle: got %0d expected %0d", stat_stall_cycles, es);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = '1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (req_ready !== (N'(1) << c)) begin
            n_fail++;
            $display("FAIL bp_ready[%0d]: got %b expected %b", c, req_ready, N'(1) << c);
         end
         step();
      end
      fiu_almost_full = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== '0 || tx_valid !== 1'b1 || tx_req_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL bp_first: got r=%b v=%b i=%0d expected r=0000 v=1 i=2", req_ready, tx_valid, tx_req_idx);
      end
      step();
      #1;
      n_tests++;
      if (req_ready !== '0 || tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_second: got r=%b v=%b expected r=0000 v=0", req_ready, tx_valid);
      end
      step();
      fiu_almost_full = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL bp_resume: got %b expected 1000", req_ready);
      end
      exp_q.push_back(2'd3);
      step();
      check_tx_pop("bp_resume_tx");
      req_valid = '0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      req_valid = 4'b0010;
      for (int c = 0; c < 3; c++) step();
      n_tests++;
      if (dut.cnt[1] !== 4'd3 || dut.total_cnt !== 4'd3) begin
         n_fail++;
         $display("FAIL sim_setup: got cnt1=%0d total=%0d expected 3 3", dut.cnt[1], dut.total_cnt);
      end
      rsp_valid = 1'b1; rsp_eop = 1'b1; rsp_req_idx = 2'd1;
      #1;
      n_tests++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL sim_ready: got %b expected 0010", req_ready);
      end
      step();
      rsp_valid = 1'b0; rsp_eop = 1'b0; req_valid = '0;
      n_tests++;
      if (dut.cnt[1] !== 4'd3 || dut.total_cnt !== 4'd3 || tx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sim_same_req: got cnt1=%0d total=%0d v=%b expected 3 3 1", dut.cnt[1], dut.total_cnt, tx_valid);
      end
      rsp_valid = 1'b1; rsp_eop = 1'b0; rsp_req_idx = 2'd1;
      step();
      rsp_valid = 1'b0;
      n_tests++;
      if (dut.cnt[1] !== 4'd3 || dut.total_cnt !== 4'd3 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL sim_non_eop: got cnt1=%0d total=%0d err=%b expected 3 3 0", dut.cnt[1], dut.total_cnt, err_underflow);
      end
      req_valid = 4'b0001;
      rsp_valid = 1'b1; rsp_eop = 1'b1; rsp_req_idx = 2'd1;
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL sim_diff_ready: got %b expected 0001", req_ready);
      end
      step();
      rsp_valid = 1'b0; rsp_eop = 1'b0; req_valid = '0;
      n_tests++;
      if (dut.cnt[0] !== 4'd1 || dut.cnt[1] !== 4'd2 || dut.total_cnt !== 4'd3) begin
         n_fail++;
         $display("FAIL sim_diff_req: got cnt0=%0d cnt1=%0d total=%0d expected 1 2 3", dut.cnt[0], dut.cnt[1], dut.total_cnt);
      end
   endtask

   task automatic test_underflow_reset();
      do_reset();
      rsp_valid = 1'b1; rsp_eop = 1'b1; rsp_req_idx = 2'd3;
      #1;
      n_tests++;
      if (err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL uf_early: got %b expected 0", err_underflow);
      end
      step();
      rsp_valid = 1'b0; rsp_eop = 1'b0;
      n_tests++;
      if (err_underflow !== 1'b1 || dut.cnt[3] !== 4'd0 || dut.total_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL uf_set: got err=%b cnt3=%0d total=%0d expected 1 0 0", err_underflow, dut.cnt[3], dut.total_cnt);
      end
      step();
      n_tests++;
      if (err_underflow !== 1'b1) begin
         n_fail++;
         $display("FAIL uf_sticky: got %b expected 1", err_underflow);
      end
      req_valid = '1;
      step();
      step();
      #1;
      reset = 1'b1;
      #1;
      n_tests++;
      if (tx_valid !== 1'b0 || tx_addr !== '0 || tx_mdata !== '0 || tx_req_idx !== '0 ||
          req_ready !== '0 || err_underflow !== 1'b0 || stat_stall_cycles !== 32'd0 ||
          dut.total_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_mid: got v=%b a=%h m=%h i=%0d r=%b e=%b s=%0d t=%0d expected all 0",
                  tx_valid, tx_addr, tx_mdata, tx_req_idx, req_ready, err_underflow, stat_stall_cycles, dut.total_cnt);
      end
      step();
      reset = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rst_first_grant: got %b expected 0001", req_ready);
      end
      exp_q.push_back(2'd0);
      step();
      check_tx_pop("rst_first_tx");
      req_valid = '0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = addr_of(i);
         req_mdata[i*MW +: MW] = mdata_of(i);
      end
      req_valid = '0; fiu_almost_full = 1'b0;
      rsp_valid = 1'b0; rsp_eop = 1'b0; rsp_req_idx = '0;
      reset = 1'b1;
      test_reset();
      test_fairness();
      test_global_limit();
      test_per_req_limit();
      test_backpressure();
      test_simultaneous();
      test_underflow_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
